// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep controller for a DDS core: steps a tuning word from
// start_w toward stop_w, holding each word dwell+1 cycles, with loop and abort.
module dds_sweep_ctrl #(
  parameter int tune = 16,
  parameter int dw   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [tune-1:0] start_w,
  input  logic [tune-1:0] stop_w,
  input  logic [tune-1:0] step_w,
  input  logic [dw-1:0]   dwell,
  input  logic [2:0]      wave_sel,
  input  logic            loop,
  output logic [tune-1:0] tuningW,
  output logic [2:0]      sel,
  output logic            busy,
  output logic            done,
  output logic            upd
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e          state_q, state_d;
  logic [tune-1:0] tw_q, tw_d;
  logic [tune-1:0] start_q, start_d;
  logic [tune-1:0] stop_q, stop_d;
  logic [tune-1:0] step_q, step_d;
  logic [dw-1:0]   dwell_q, dwell_d;
  logic [dw-1:0]   cnt_q, cnt_d;
  logic [2:0]      sel_q, sel_d;
  logic            loop_q, loop_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            upd_q, upd_d;
  logic [tune-1:0] next_w;

  // Saturating step: compare remaining distance with the step so the sum
  // never has to be formed past the tune-bit range.
  always_comb begin
    if (start_q <= stop_q)
      next_w = ((stop_q - tw_q) < step_q) ? stop_q : tw_q + step_q;
    else
      next_w = ((tw_q - stop_q) < step_q) ? stop_q : tw_q - step_q;
  end

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    tw_d    = tw_q;
    start_d = start_q;
    stop_d  = stop_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    upd_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          start_d = start_w;
          stop_d  = stop_w;
          step_d  = step_w;
          dwell_d = dwell;
          loop_d  = loop;
          tw_d    = start_w;
          sel_d   = wave_sel;
          cnt_d   = '0;
          upd_d   = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          tw_d    = '0;
          cnt_d   = '0;
        end else if (cnt_q != dwell_q) begin
          cnt_d = cnt_q + dw'(1);
        end else if (tw_q == stop_q || step_q == '0) begin
          cnt_d = '0;
          if (loop_q) begin
            tw_d  = start_q;
            upd_d = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          tw_d  = next_w;
          cnt_d = '0;
          upd_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the latched sweep parameters are cleared too; they are only
      // read in RUN, but a defined value keeps simulation free of X.
      state_q <= IDLE;
      tw_q    <= '0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      loop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tw_q    <= tw_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      loop_q  <= loop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      upd_q   <= upd_d;
    end
  end

  assign tuningW = tw_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign upd     = upd_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: expected word sequences come from an
// arithmetic sweep model; a negedge monitor checks each upd/done event.
module tb_dds_sweep_ctrl;
  localparam int TUNE = 16;
  localparam int DW   = 16;

  logic            clk = 1'b0;
  logic            rst_n, start, abort, loop;
  logic [TUNE-1:0] start_w, stop_w, step_w;
  logic [DW-1:0]   dwell;
  logic [2:0]      wave_sel;
  logic [TUNE-1:0] tuningW;
  logic [2:0]      sel;
  logic            busy, done, upd;

  dds_sweep_ctrl #(.tune(TUNE), .dw(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .start_w(start_w), .stop_w(stop_w), .step_w(step_w), .dwell(dwell),
    .wave_sel(wave_sel), .loop(loop), .tuningW(tuningW), .sel(sel),
    .busy(busy), .done(done), .upd(upd)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int word;
    int wsel;
    int gap;   // cycles since previous event; 0 = not checked
  } ev_t;

  ev_t exp_q[$];
  int  words[$];
  int  n_checks = 0;
  int  n_err    = 0;
  int  cyc      = 0;
  int  last_ev  = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every upd or done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (upd || done)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", exp_q.size(), 1);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("event_is_done", done, e.is_done);
        if (!e.is_done) begin
          check("tuningW", tuningW, e.word);
          check("sel", sel, e.wsel);
          check("busy_on_upd", busy, 1);
        end else begin
          check("busy_on_done", busy, 0);
        end
        if (e.gap > 0) check("event_gap", cyc - last_ev, e.gap);
      end
      last_ev = cyc;
    end
  end

  // Reference sweep: plain integer walk from s toward st, clamped at st.
  task automatic gen_words(input int s, input int st, input int sp);
    int w;
    words.delete();
    w = s;
    words.push_back(w);
    if (sp != 0) begin
      while (w != st) begin
        if (s <= st) begin
          w = w + sp;
          if (w > st) w = st;
        end else begin
          w = w - sp;
          if (w < st) w = st;
        end
        words.push_back(w);
      end
    end
  endtask

  task automatic issue(input int s, input int st, input int sp, input int d,
                       input int ws, input bit lp, input int passes);
    ev_t e;
    gen_words(s, st, sp);
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < words.size(); i++) begin
        e.is_done = 1'b0;
        e.word    = words[i];
        e.wsel    = ws;
        e.gap     = (p == 0 && i == 0) ? 0 : d + 1;
        exp_q.push_back(e);
      end
    end
    if (!lp) begin
      e.is_done = 1'b1;
      e.word    = 0;
      e.wsel    = 0;
      e.gap     = d + 1;
      exp_q.push_back(e);
    end
    start_w  = TUNE'(s);
    stop_w   = TUNE'(st);
    step_w   = TUNE'(sp);
    dwell    = DW'(d);
    wave_sel = 3'(ws);
    loop     = lp;
    start    = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for the scoreboard to empty; optionally scrambles inputs and pulses
  // start while the sweep is guaranteed still running.
  task automatic drain(input bit lp, input bit scr);
    int budget = 2000;
    while (exp_q.size() != 0 && budget > 0) begin
      if (scr) begin
        start_w  = TUNE'($urandom);
        stop_w   = TUNE'($urandom);
        step_w   = TUNE'($urandom);
        dwell    = DW'($urandom_range(0, 5));
        wave_sel = 3'($urandom);
        loop     = 1'($urandom);
        start    = (exp_q.size() >= (lp ? 1 : 2)) ? 1'($urandom) : 1'b0;
      end
      @(negedge clk); #1;
      budget--;
    end
    start = 1'b0;
    check("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic finish_nonloop(input int ws);
    check("hold_tuningW", tuningW, words[words.size()-1]);
    check("hold_sel", sel, ws);
    check("idle_busy", busy, 0);
  endtask

  task automatic finish_loop();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_tuningW", tuningW, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_upd", upd, 0);
    @(negedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tuningW"}, tuningW, 0);
    check({tag, "_sel"}, sel, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_upd"}, upd, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; loop = 1'b0;
    start_w = '0; stop_w = '0; step_w = '0; dwell = '0; wave_sel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Directed sweeps; back-to-back issues land start in the done cycle.
    issue(100, 300, 50, 2, 3, 1'b0, 1);  drain(1'b0, 1'b0); finish_nonloop(3);
    issue(100, 300, 70, 0, 5, 1'b0, 1);  drain(1'b0, 1'b1); finish_nonloop(5);
    issue(300, 100, 100, 1, 1, 1'b0, 1); drain(1'b0, 1'b1); finish_nonloop(1);
    issue(16'hFF00, 16'hFFFF, 16'h0200, 0, 2, 1'b0, 1); drain(1'b0, 1'b0);
    finish_nonloop(2);
    issue(200, 200, 7, 3, 4, 1'b0, 1);   drain(1'b0, 1'b0); finish_nonloop(4);
    issue(50, 400, 0, 1, 6, 1'b0, 1);    drain(1'b0, 1'b0); finish_nonloop(6);

    // Abort in IDLE must not disturb the held word.
    abort = 1'b1;
    @(negedge clk); #1;
    abort = 1'b0;
    check("idle_abort_tuningW", tuningW, 50);
    check("idle_abort_busy", busy, 0);

    issue(10, 30, 10, 0, 7, 1'b1, 3); drain(1'b1, 1'b1); finish_loop();

    // Reset in the middle of a long sweep.
    issue(0, 60000, 100, 1, 2, 1'b0, 1);
    repeat (20) begin @(negedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midreset");
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk); #1;

    for (int n = 0; n < 14; n++) begin
      int s, st, sp, d, ws, diff;
      bit lp;
      s    = $urandom_range(0, 65535);
      st   = $urandom_range(0, 65535);
      diff = (s > st) ? s - st : st - s;
      sp   = ($urandom_range(0, 7) == 0) ? 0
             : $urandom_range(diff / 25 + 1, diff / 25 + diff / 3 + 2);
      d    = $urandom_range(0, 3);
      ws   = $urandom_range(0, 7);
      lp   = ($urandom_range(0, 3) == 0);
      issue(s, st, sp, d, ws, lp, lp ? 2 : 1);
      drain(lp, 1'($urandom));
      if (lp) finish_loop();
      else    finish_nonloop(ws);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
